// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, word-length encodings and
// the parity helper used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   localparam int OVERSAMPLE_DEFAULT = 16;

   // Index of the last data bit for a word length: 5 bits -> 4 ... 8 bits -> 7.
   function automatic logic [2:0] wls_last(input logic [1:0] wls);
      return {1'b1, wls};
   endfunction

   // XOR of the data bits that are actually sent for this word length.
   function automatic logic even_parity(input logic [7:0] data, input logic [1:0] wls);
      logic [7:0] mask;
      mask = 8'hFF >> {1'b0, ~wls};
      return ^(data & mask);
   endfunction

endpackage

// File: rtl/baud_tick_detect.sv
// Synchronises the oversampled baud clock into CLK and emits a one-cycle
// TICK on each rising edge.
module baud_tick_detect (
   input  logic CLK,
   input  logic RST_N,
   input  logic BAUDOUT_CLK,
   output logic TICK
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= BAUDOUT_CLK;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign TICK = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: THR/TSR pair serialised as start, 5-8 data bits LSB
// first, optional parity and 1 or 2 stop bits, paced by the baud tick.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       BAUDOUT_CLK,
   input  logic [7:0] TX_DATA,
   input  logic       TX_LOAD,
   input  logic [1:0] WLS,
   input  logic       STB,
   input  logic       PEN,
   input  logic       EPS,
   input  logic       SP,
   input  logic       BREAK,
   output logic       SOUT,
   output logic       THR_EMPTY,
   output logic       TSR_EMPTY,
   output logic [2:0] STATE_DBG
);

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   tx_state_t  state_q, state_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic [7:0] tsr_q, tsr_d;
   logic [7:0] thr_q;
   logic       thr_full_q;
   logic [1:0] wls_q;
   logic       stb_q;
   logic       pen_q;
   logic       par_q;
   logic       par_d;
   logic       sout_q, sout_d;
   logic       tick;
   logic       bit_end;
   logic       xfer;

   baud_tick_detect u_tick (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .BAUDOUT_CLK (BAUDOUT_CLK),
      .TICK        (tick)
   );

   assign bit_end = tick && (tick_cnt_q == TICK_LAST);

   // Stick parity wins; otherwise EPS selects even (XOR) or odd (inverted XOR).
   assign par_d = SP ? ~EPS : ~(even_parity(thr_q, WLS) ^ EPS);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tsr_d      = tsr_q;
      xfer       = 1'b0;
      sout_d     = 1'b1;

      if (tick && state_q != IDLE) begin
         tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (tick && thr_full_q) xfer = 1'b1;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               tsr_d = {1'b0, tsr_q[7:1]};
               if (bit_cnt_q == wls_last(wls_q)) begin
                  state_d    = pen_q ? PARITY : STOP;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stb_q && !stop_cnt_q) stop_cnt_d = 1'b1;
               else if (thr_full_q)      xfer       = 1'b1;
               else                      state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A transfer from IDLE or from the last stop tick starts the next frame
      // directly, so back-to-back frames have no idle bit between them.
      if (xfer) begin
         state_d    = START;
         tick_cnt_d = 4'd0;
         tsr_d      = thr_q;
      end

      case (state_d)
         START:   sout_d = 1'b0;
         DATA:    sout_d = tsr_d[0];
         PARITY:  sout_d = par_q;
         default: sout_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         tick_cnt_q <= 4'd0;
         bit_cnt_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         tsr_q      <= 8'd0;
         sout_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tsr_q      <= tsr_d;
         sout_q     <= sout_d;
      end
   end

   // A load coinciding with a transfer keeps the THR full with the new byte.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         thr_q      <= 8'd0;
         thr_full_q <= 1'b0;
      end else if (TX_LOAD) begin
         thr_q      <= TX_DATA;
         thr_full_q <= 1'b1;
      end else if (xfer) begin
         thr_full_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wls_q <= WLS_8;
         stb_q <= 1'b0;
         pen_q <= 1'b0;
         par_q <= 1'b0;
      end else if (xfer) begin
         wls_q <= WLS;
         stb_q <= STB;
         pen_q <= PEN;
         par_q <= par_d;
      end
   end

   assign SOUT      = sout_q & ~BREAK;
   assign THR_EMPTY = ~thr_full_q;
   assign TSR_EMPTY = (state_q == IDLE) & ~thr_full_q;
   assign STATE_DBG = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a 2-CLK baud tick (32 CLK per bit).
module tb_uart_transmitter;

   logic       CLK;
   logic       RST_N;
   logic       BAUDOUT_CLK;
   logic [7:0] TX_DATA;
   logic       TX_LOAD;
   logic [1:0] WLS;
   logic       STB;
   logic       PEN;
   logic       EPS;
   logic       SP;
   logic       BREAK;
   logic       SOUT;
   logic       THR_EMPTY;
   logic       TSR_EMPTY;
   logic [2:0] STATE_DBG;
   logic       baud_en;

   int total = 0;
   int bad   = 0;

   uart_transmitter dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .BAUDOUT_CLK (BAUDOUT_CLK),
      .TX_DATA     (TX_DATA),
      .TX_LOAD     (TX_LOAD),
      .WLS         (WLS),
      .STB         (STB),
      .PEN         (PEN),
      .EPS         (EPS),
      .SP          (SP),
      .BREAK       (BREAK),
      .SOUT        (SOUT),
      .THR_EMPTY   (THR_EMPTY),
      .TSR_EMPTY   (TSR_EMPTY),
      .STATE_DBG   (STATE_DBG)
   );

   // clock / reset / baud source
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(negedge CLK) begin
      if (baud_en) BAUDOUT_CLK = ~BAUDOUT_CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic load(input logic [7:0] d);
      @(negedge CLK);
      TX_DATA = d;
      TX_LOAD = 1'b1;
      @(negedge CLK);
      TX_LOAD = 1'b0;
   endtask

   task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                          input logic e, input logic k);
      WLS = w; STB = s; PEN = p; EPS = e; SP = k;
   endtask

   task automatic wait_low(output int n);
      n = 0;
      while (SOUT !== 1'b0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("fall_timeout", 32'(n < 300), 32'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (TSR_EMPTY !== 1'b1 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("idle_timeout", 32'(n < 2000), 32'd1);
   endtask

   task automatic wait_thr_empty();
      int n;
      n = 0;
      while (THR_EMPTY !== 1'b1 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      chk("thr_empty_timeout", 32'(n < 300), 32'd1);
   endtask

   // Samples each bit at its centre; bits[0] is the start bit.
   task automatic check_frame(input string tag, input logic [15:0] bits,
                              input int nbits, input bit sync);
      int n;
      if (sync) begin
         wait_low(n);
         repeat (16) @(negedge CLK);
      end else begin
         repeat (32) @(negedge CLK);
      end
      for (int i = 0; i < nbits; i++) begin
         if (i > 0) repeat (32) @(negedge CLK);
         chk($sformatf("%s_bit%0d", tag, i), 32'(SOUT), 32'(bits[i]));
         chk($sformatf("%s_busy%0d", tag, i), 32'(TSR_EMPTY), 32'd0);
      end
   endtask

   initial begin
      int n;
      int len;
      int cnt;
      logic v;

      RST_N = 1'b0; BAUDOUT_CLK = 1'b0; baud_en = 1'b0;
      TX_DATA = 8'h00; TX_LOAD = 1'b0; BREAK = 1'b0;
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      chk("rst_sout", 32'(SOUT), 32'd1);
      chk("rst_thr_empty", 32'(THR_EMPTY), 32'd1);
      chk("rst_tsr_empty", 32'(TSR_EMPTY), 32'd1);
      chk("rst_state", 32'(STATE_DBG), 32'd0);
      RST_N = 1'b1;
      baud_en = 1'b1;
      repeat (20) @(negedge CLK);
      chk("idle_sout", 32'(SOUT), 32'd1);

      // 8N1 0x55: exact 32-cycle levels and start latency
      load(8'h55);
      wait_low(n);
      chk("load_latency", 32'(n <= 3), 32'd1);
      for (int lv = 0; lv < 9; lv++) begin
         v = lv[0];
         len = 0;
         while (SOUT === v && len < 100) begin
            len++;
            @(negedge CLK);
         end
         chk($sformatf("level%0d_len", lv), 32'(len), 32'd32);
      end
      chk("stop_level", 32'(SOUT), 32'd1);
      repeat (31) @(negedge CLK);
      chk("stop_last_busy", 32'(TSR_EMPTY), 32'd0);
      @(negedge CLK);
      chk("tsr_empty_after", 32'(TSR_EMPTY), 32'd1);

      // 7E1 and 7O1 on 0xC1
      set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      load(8'hC1);
      check_frame("7e1", {6'b0, 1'b1, 1'b0, 7'b1000001, 1'b0}, 10, 1'b1);
      wait_idle();
      set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      load(8'hC1);
      check_frame("7o1", {6'b0, 1'b1, 1'b1, 7'b1000001, 1'b0}, 10, 1'b1);
      wait_idle();

      // back-to-back with overwrite of the pending byte
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      load(8'hA5);
      wait_thr_empty();
      load(8'h3C);
      load(8'h7E);
      chk("thr_full", 32'(THR_EMPTY), 32'd0);
      check_frame("b2b_a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b1);
      check_frame("b2b_7e", {6'b0, 1'b1, 8'h7E, 1'b0}, 10, 1'b0);
      wait_idle();
      repeat (100) @(negedge CLK);
      chk("b2b_no_third", 32'(SOUT), 32'd1);

      // 5 bits, stick parity (EPS=0 -> 1), two stop bits
      set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
      load(8'h1F);
      check_frame("5s2", {7'b0, 1'b1, 1'b1, 1'b1, 5'b11111, 1'b0}, 9, 1'b1);
      wait_idle();

      // break for 3 bit times, frame keeps advancing underneath
      set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      load(8'hBE);
      wait_low(n);
      repeat (16 + 64) @(negedge CLK);
      chk("brk_bit1", 32'(SOUT), 32'd1);
      BREAK = 1'b1;
      cnt = 0;
      repeat (96) begin
         @(negedge CLK);
         if (SOUT !== 1'b0) cnt++;
      end
      chk("brk_hold", 32'(cnt), 32'd0);
      BREAK = 1'b0;
      repeat (32) @(negedge CLK);
      chk("brk_bit5", 32'(SOUT), 32'd1);
      repeat (32) @(negedge CLK);
      chk("brk_bit6", 32'(SOUT), 32'd0);
      repeat (32) @(negedge CLK);
      chk("brk_bit7", 32'(SOUT), 32'd1);
      repeat (32) @(negedge CLK);
      chk("brk_stop", 32'(SOUT), 32'd1);
      wait_idle();

      // reset during data bit 3 with a byte pending
      load(8'h00);
      wait_low(n);
      repeat (16 + 4 * 32) @(negedge CLK);
      chk("rst_pre_bit3", 32'(SOUT), 32'd0);
      load(8'hAA);
      chk("rst_pre_thr", 32'(THR_EMPTY), 32'd0);
      RST_N = 1'b0;
      #1;
      chk("midrst_sout", 32'(SOUT), 32'd1);
      chk("midrst_thr_empty", 32'(THR_EMPTY), 32'd1);
      chk("midrst_tsr_empty", 32'(TSR_EMPTY), 32'd1);
      chk("midrst_state", 32'(STATE_DBG), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      cnt = 0;
      repeat (400) begin
         @(negedge CLK);
         if (SOUT !== 1'b1) cnt++;
      end
      chk("post_rst_quiet", 32'(cnt), 32'd0);
      chk("post_rst_thr_empty", 32'(THR_EMPTY), 32'd1);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
